// File: rtl/match_result_ctrl.sv
// match_result_ctrl: match supervisor that sits upstream of the end-screen renderer.
// It counts rally points, times the serve pause and detects the end of the match.
// It latches the outcome for the end screen and handles the start and home buttons.
//
// Ports:
//   clk_100MHz   system clock
//   reset        synchronous, active-high reset
//   point_p1     one-cycle pulse: player scored
//   point_p2     one-cycle pulse: CPU scored
//   start_btn    debounced level, start/restart
//   home_btn     debounced level, return to home
//   game_active  high in PLAY; gates ball motion
//   serve_wait   high in SERVE
//   score_p1/p2  4-bit scores
//   enable       end-screen enable, high in OVER
//   result       1 = player won; held through OVER
//   win/lose     one-hot outcome flags in OVER
//   blink        end-screen blink, toggles every BLINK_CYCLES in OVER
module match_result_ctrl #(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_CYCLES = 50_000_000,
    parameter int HOLD_CYCLES  = 200_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       start_btn,
    input  logic       home_btn,
    output logic       game_active,
    output logic       serve_wait,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       enable,
    output logic       result,
    output logic       win,
    output logic       lose,
    output logic       blink
);

    localparam int SW = $clog2(SERVE_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int BW = $clog2(BLINK_CYCLES) + 1;

    typedef enum logic [1:0] {HOME, PLAY, SERVE, OVER} state_t;

    state_t        state_q;
    logic [SW-1:0] serve_cnt_q;
    logic [HW-1:0] hold_cnt_q;
    logic [BW-1:0] blink_cnt_q;
    logic          start_prev_q, home_prev_q;

    logic       start_edge, home_edge, hold_done;
    logic [3:0] p1_next, p2_next;

    assign start_edge = start_btn & ~start_prev_q;
    assign home_edge  = home_btn & ~home_prev_q;
    assign hold_done  = (hold_cnt_q == HW'(HOLD_CYCLES));
    assign p1_next    = score_p1 + 4'd1;
    assign p2_next    = score_p2 + 4'd1;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q      <= HOME;
            serve_cnt_q  <= '0;
            hold_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            // History starts high so a button held through reset gives no edge
            start_prev_q <= 1'b1;
            home_prev_q  <= 1'b1;
            game_active  <= 1'b0;
            serve_wait   <= 1'b0;
            score_p1     <= '0;
            score_p2     <= '0;
            enable       <= 1'b0;
            result       <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
            blink        <= 1'b0;
        end else begin
            start_prev_q <= start_btn;
            home_prev_q  <= home_btn;
            case (state_q)
                HOME: begin
                    if (start_edge) begin
                        state_q     <= PLAY;
                        game_active <= 1'b1;
                        score_p1    <= '0;
                        score_p2    <= '0;
                    end
                end
                PLAY: begin
                    if (home_edge) begin
                        state_q     <= HOME;
                        game_active <= 1'b0;
                    end else if (point_p1 || point_p2) begin
                        game_active <= 1'b0;
                        // Player's point wins a tie; the CPU pulse is dropped
                        if (point_p1) score_p1 <= p1_next;
                        else          score_p2 <= p2_next;
                        if ((point_p1 && p1_next == 4'(WIN_SCORE)) ||
                            (!point_p1 && p2_next == 4'(WIN_SCORE))) begin
                            state_q     <= OVER;
                            enable      <= 1'b1;
                            result      <= point_p1;
                            win         <= point_p1;
                            lose        <= ~point_p1;
                            hold_cnt_q  <= '0;
                            blink_cnt_q <= '0;
                            blink       <= 1'b0;
                        end else begin
                            state_q     <= SERVE;
                            serve_wait  <= 1'b1;
                            serve_cnt_q <= '0;
                        end
                    end
                end
                SERVE: begin
                    if (home_edge) begin
                        state_q    <= HOME;
                        serve_wait <= 1'b0;
                    end else if (serve_cnt_q == SW'(SERVE_CYCLES - 1)) begin
                        state_q     <= PLAY;
                        serve_wait  <= 1'b0;
                        game_active <= 1'b1;
                        serve_cnt_q <= '0;
                    end else begin
                        serve_cnt_q <= serve_cnt_q + SW'(1);
                    end
                end
                OVER: begin
                    if (!hold_done) hold_cnt_q <= hold_cnt_q + HW'(1);
                    if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
                        blink_cnt_q <= '0;
                        blink       <= ~blink;
                    end else begin
                        blink_cnt_q <= blink_cnt_q + BW'(1);
                    end
                    // Exit clears override the blink update above; home wins a tie
                    if (hold_done && (start_edge || home_edge)) begin
                        state_q     <= home_edge ? HOME : PLAY;
                        game_active <= ~home_edge;
                        score_p1    <= '0;
                        score_p2    <= '0;
                        enable      <= 1'b0;
                        result      <= 1'b0;
                        win         <= 1'b0;
                        lose        <= 1'b0;
                        blink       <= 1'b0;
                    end
                end
                default: state_q <= HOME;
            endcase
        end
    end

endmodule

// File: tb/tb_match_result_ctrl.sv
module tb_match_result_ctrl;

    typedef struct packed {
        logic       ga;
        logic       sw;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       en;
        logic       res;
        logic       win;
        logic       lose;
        logic       blink;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p1 = 1'b0, p2 = 1'b0, st = 1'b1, hm = 1'b0;
    logic       game_active, serve_wait, enable, result, win, lose, blink;
    logic [3:0] score_p1, score_p2;

    int    checks = 0;
    int    errors = 0;
    outs_t exp_o;
    outs_t sb_q[$];

    always #5 clk = ~clk;

    match_result_ctrl #(
        .WIN_SCORE(3), .SERVE_CYCLES(4), .HOLD_CYCLES(8), .BLINK_CYCLES(2)
    ) dut (
        .clk_100MHz (clk),
        .reset      (rst),
        .point_p1   (p1),
        .point_p2   (p2),
        .start_btn  (st),
        .home_btn   (hm),
        .game_active(game_active),
        .serve_wait (serve_wait),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .enable     (enable),
        .result     (result),
        .win        (win),
        .lose       (lose),
        .blink      (blink)
    );

    // Drive one cycle of inputs, queue the expected outputs after the edge, then check.
    task automatic cyc(input logic ip1, input logic ip2, input logic ist, input logic ihm,
                       input string tag);
        outs_t got, e;
        p1 = ip1; p2 = ip2; st = ist; hm = ihm;
        sb_q.push_back(exp_o);
        @(posedge clk);
        #1;
        got = {game_active, serve_wait, score_p1, score_p2, enable, result, win, lose, blink};
        e = sb_q.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, e);
        end
    endtask

    // Remainder of a serve pause after the point edge: 3 more SERVE cycles, then PLAY.
    task automatic serve_rest(input logic p1_first);
        exp_o.ga = 1'b0;
        exp_o.sw = 1'b1;
        for (int i = 0; i < 3; i++) cyc((i == 0) ? p1_first : 1'b0, 1'b0, 1'b0, 1'b0, "serve_hold");
        exp_o.sw = 1'b0;
        exp_o.ga = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "serve_end");
    endtask

    // OVER dwell: edges 1..9 after entry with optional start on hold cycle 3.
    task automatic over_hold(input logic early_start);
        exp_o.ga = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            exp_o.blink = ((j / 2) % 2) == 1;
            cyc(1'b0, 1'b0, early_start && (j == 3), 1'b0, "over_hold");
        end
    endtask

    initial begin
        exp_o = '0;
        repeat (2) @(posedge clk);
        #1;
        // 1. reset with start already held, then release and press
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "reset_state");
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "held_start_no_edge");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "held_start_still_home");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "release_home");
        exp_o.ga = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "start_to_play");

        // 4. simultaneous points at 0/0: only player counts
        exp_o.ga = 1'b0; exp_o.sw = 1'b1; exp_o.s1 = 4'd1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "simul_points");
        serve_rest(1'b0);

        // 2. CPU point, player pulse during SERVE ignored
        exp_o.ga = 1'b0; exp_o.sw = 1'b1; exp_o.s2 = 4'd1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "p2_point");
        serve_rest(1'b1);

        // 3. player wins
        exp_o.ga = 1'b0; exp_o.sw = 1'b1; exp_o.s1 = 4'd2;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "p1_point2");
        serve_rest(1'b0);
        exp_o = '{ga: 1'b0, sw: 1'b0, s1: 4'd3, s2: 4'd1, en: 1'b1, res: 1'b1,
                  win: 1'b1, lose: 1'b0, blink: 1'b0};
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "p1_match_win");

        // 5. early start ignored, start after hold restarts with clears
        over_hold(1'b1);
        exp_o = '0;
        exp_o.ga = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "restart_after_hold");

        // CPU wins, then simultaneous home+start -> HOME
        for (int k = 1; k <= 2; k++) begin
            exp_o.ga = 1'b0; exp_o.sw = 1'b1; exp_o.s2 = 4'(k);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, "p2_point_n");
            serve_rest(1'b0);
        end
        exp_o = '{ga: 1'b0, sw: 1'b0, s1: 4'd0, s2: 4'd3, en: 1'b1, res: 1'b0,
                  win: 1'b0, lose: 1'b1, blink: 1'b0};
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "p2_match_win");
        over_hold(1'b0);
        exp_o = '0;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "home_priority");

        // 6. reset mid-SERVE at 2/1
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "home_idle");
        exp_o.ga = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "start_again");
        for (int k = 1; k <= 2; k++) begin
            exp_o.ga = 1'b0; exp_o.sw = 1'b1; exp_o.s1 = 4'(k);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, "p1_point_n");
            serve_rest(1'b0);
        end
        exp_o.ga = 1'b0; exp_o.sw = 1'b1; exp_o.s2 = 4'd1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "p2_before_reset");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "serve_before_reset");
        rst = 1'b1;
        exp_o = '0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "reset_mid_serve");
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "home_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
